// File: rtl/fp_div_pkg.sv
// Shared definitions for the iterative floating-point divider.
//   state_e      : controller states
//   fp_class_e   : operand class after denormals-are-zero decode
//   FLG_*        : bit positions inside the 5-bit flag vector
//   fp_classify  : class decode for any exponent/mantissa width up to 16/64 bits
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    localparam int FLG_INV  = 4;
    localparam int FLG_DIVZ = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_UNF  = 1;
    localparam int FLG_INX  = 0;

    // Callers zero-extend their fields; exp_w tells which exponent value is all-ones.
    // Exponent 0 is always zero: denormal inputs are treated as signed zero.
    function automatic fp_class_e fp_classify(input logic [15:0] exp_f,
                                              input logic [63:0] mant_f,
                                              input int          exp_w);
        logic [15:0] ones;
        ones = 16'((32'd1 << exp_w) - 32'd1);
        if (exp_f == '0)
            return CLS_ZERO;
        if (exp_f != ones)
            return CLS_NORM;
        return (mant_f == '0) ? CLS_INF : CLS_NAN;
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational result stage of the divider: special-case selection,
// normalisation, round-to-nearest-even, exponent and range handling, flags.
//   a, b      : latched operands
//   quot      : QB quotient bits of {1,mant_a}/{1,mant_b}, MSB is the integer bit
//   rem_nz    : final partial remainder is nonzero
//   res_data  : packed result
//   res_flags : {invalid, divz, overflow, underflow, inexact}
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MANT_W = 23,
    localparam int W = 1 + EXP_W + MANT_W,
    localparam int QB = MANT_W + 3
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [QB-1:0] quot,
    input  logic          rem_nz,
    output logic [W-1:0]  res_data,
    output logic [4:0]    res_flags
);
    localparam int EW = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]         QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

    fp_class_e cls_a, cls_b;
    logic sgn;
    logic [EXP_W-1:0] ea, eb;
    logic signed [EW-1:0] e_base, e_norm, e_fin;
    logic [MANT_W-1:0] m_pre, m_rnd;
    logic g, r, up, carry, inexact;

    assign cls_a = fp_classify(16'(a[W-2:MANT_W]), 64'(a[MANT_W-1:0]), EXP_W);
    assign cls_b = fp_classify(16'(b[W-2:MANT_W]), 64'(b[MANT_W-1:0]), EXP_W);
    assign sgn   = a[W-1] ^ b[W-1];
    assign ea    = a[W-2:MANT_W];
    assign eb    = b[W-2:MANT_W];

    // Extra two exponent bits hold both the overflow headroom and the sign of underflow.
    assign e_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;

    // Quotient below 1: shift left one place; the vacated round position reads 0,
    // its information is still captured by the remainder in the sticky bit.
    always_comb begin
        if (quot[QB-1]) begin
            m_pre  = quot[QB-2:2];
            g      = quot[1];
            r      = quot[0];
            e_norm = e_base;
        end else begin
            m_pre  = quot[QB-3:1];
            g      = quot[0];
            r      = 1'b0;
            e_norm = e_base - ONE_S;
        end
    end

    assign up               = g & (r | rem_nz | m_pre[0]);
    assign {carry, m_rnd}   = {1'b0, m_pre} + {{MANT_W{1'b0}}, up};
    assign e_fin            = carry ? (e_norm + ONE_S) : e_norm;
    assign inexact          = g | r | rem_nz;

    always_comb begin
        res_data  = '0;
        res_flags = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            res_data           = QNAN;
            res_flags[FLG_INV] = 1'b1;
        end else if (cls_a == CLS_NORM && cls_b == CLS_ZERO) begin
            res_data            = {sgn, EXP_ONES, {MANT_W{1'b0}}};
            res_flags[FLG_DIVZ] = 1'b1;
        end else if (cls_a == CLS_INF) begin
            res_data = {sgn, EXP_ONES, {MANT_W{1'b0}}};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            res_data = {sgn, {(W-1){1'b0}}};
        end else if (e_fin >= EMAX_S) begin
            res_data           = {sgn, EXP_ONES, {MANT_W{1'b0}}};
            res_flags[FLG_OVF] = 1'b1;
            res_flags[FLG_INX] = 1'b1;
        end else if (e_fin <= ZERO_S) begin
            res_data           = {sgn, {(W-1){1'b0}}};
            res_flags[FLG_UNF] = 1'b1;
            res_flags[FLG_INX] = 1'b1;
        end else begin
            res_data           = {sgn, e_fin[EXP_W-1:0], m_rnd};
            res_flags[FLG_INX] = inexact;
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider, a/b, radix-2 restoring, one quotient bit per clock.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready, in_a/b/tag   : operand handshake
//   out_valid/out_ready             : result handshake
//   out_data, out_tag, out_flags    : quotient, request tag, {inv,divz,ovf,unf,inx}
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// DIV   | restoring divide, one quotient bit per cycle, QB cycles
// ROUND | normalise/round/flag, register outputs
// OUT   | out_valid high, outputs held until out_ready
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MANT_W = 23,
    parameter int TAG_W = 8,
    localparam int W = 1 + EXP_W + MANT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags
);
    localparam int QB = MANT_W + 3;
    localparam int CW = $clog2(QB);
    localparam int RW = MANT_W + 1;

    state_e state, state_nxt;
    logic [W-1:0]     a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic [RW:0]      rem_q, mb_ext, rem_nxt;
    logic [RW-1:0]    rem_sub;
    logic [QB-1:0]    quot_q;
    logic [CW-1:0]    cnt_q;
    logic             accept, in_special, qbit;
    fp_class_e        cls_a, cls_b;
    logic [W-1:0]     res_data;
    logic [4:0]       res_flags;

    assign accept     = in_valid && in_ready;
    assign cls_a      = fp_classify(16'(in_a[W-2:MANT_W]), 64'(in_a[MANT_W-1:0]), EXP_W);
    assign cls_b      = fp_classify(16'(in_b[W-2:MANT_W]), 64'(in_b[MANT_W-1:0]), EXP_W);
    assign in_special = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);

    // Partial remainder stays below 2*mb, so after a restore it fits RW bits and
    // the left shift never drops a set bit.
    assign mb_ext  = {2'b01, b_q[MANT_W-1:0]};
    assign qbit    = (rem_q >= mb_ext);
    assign rem_sub = qbit ? RW'(rem_q - mb_ext) : rem_q[RW-1:0];
    assign rem_nxt = {rem_sub, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_special ? ROUND : DIV;
            DIV:     if (cnt_q == CW'(QB - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so that in_ready stays
    // low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            out_data  <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    tag_q  <= in_tag;
                    rem_q  <= {2'b01, in_a[MANT_W-1:0]};
                    quot_q <= '0;
                    cnt_q  <= '0;
                end
                DIV: begin
                    rem_q  <= rem_nxt;
                    quot_q <= {quot_q[QB-2:0], qbit};
                    cnt_q  <= cnt_q + CW'(1);
                end
                ROUND: begin
                    out_data  <= res_data;
                    out_flags <= res_flags;
                    out_tag   <= tag_q;
                end
                default: ;
            endcase
        end
    end

    fp_div_round #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_round (
        .a         (a_q),
        .b         (b_q),
        .quot      (quot_q),
        .rem_nz    (rem_q != '0),
        .res_data  (res_data),
        .res_flags (res_flags)
    );

endmodule

// File: tb/tb_fp_div_iter.sv
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_a = '0, in_b = '0, out_data;
    logic [7:0]  in_tag = '0, out_tag;
    logic [4:0]  out_flags;

    logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
    logic [15:0] h_in_a = '0, h_in_b = '0, h_out_data;
    logic [7:0]  h_in_tag = '0, h_out_tag;
    logic [4:0]  h_out_flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_div_iter #(.EXP_W(8), .MANT_W(23), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_flags(out_flags)
    );

    fp_div_iter #(.EXP_W(5), .MANT_W(10), .TAG_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_data(h_out_data), .out_tag(h_out_tag), .out_flags(h_out_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
        logic [31:0] data;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        int          lat;
    } res_t;

    // Reference: exact rational quotient, rounded by comparing the remainder with half an ulp.
    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b,
                                     input int ew, input int mw);
        res_t        r;
        longint      emax, bias, ea, eb, fa, fb, ma, mb, num, iq, rm, e, mask;
        bit          sa, sb, s, za, zb, ia, ib, na, nb, up;
        logic [31:0] sgn, inf;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        mask = (longint'(1) << mw) - 1;
        sa = a[ew+mw];
        sb = b[ew+mw];
        s  = sa ^ sb;
        ea = (longint'(a) >> mw) & emax;
        eb = (longint'(b) >> mw) & emax;
        fa = longint'(a) & mask;
        fb = longint'(b) & mask;
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == emax) && (fa == 0);
        ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0);
        nb = (eb == emax) && (fb != 0);
        sgn = s ? (32'h1 << (ew + mw)) : 32'h0;
        inf = 32'(emax << mw);
        r.lat = 2;
        r.flags = 5'b00000;
        r.data = '0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r.data = 32'((emax << mw) | (longint'(1) << (mw - 1)));
            r.flags = 5'b10000;
        end else if (!za && !ia && zb) begin
            r.data = sgn | inf;
            r.flags = 5'b01000;
        end else if (ia) begin
            r.data = sgn | inf;
        end else if (za || ib) begin
            r.data = sgn;
        end else begin
            r.lat = mw + 5;
            ma = (longint'(1) << mw) | fa;
            mb = (longint'(1) << mw) | fb;
            e = ea - eb + bias;
            num = ma;
            if (ma < mb) begin
                num = 2 * ma;
                e = e - 1;
            end
            iq = (num << mw) / mb;
            rm = (num << mw) % mb;
            up = (2 * rm > mb) || ((2 * rm == mb) && iq[0]);
            if (up) iq = iq + 1;
            if (iq == (longint'(1) << (mw + 1))) begin
                iq = iq >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                r.data = sgn | inf;
                r.flags = 5'b00101;
            end else if (e <= 0) begin
                r.data = sgn;
                r.flags = 5'b00011;
            end else begin
                r.data = sgn | 32'((e << mw) | (iq & mask));
                r.flags = {4'b0000, rm != 0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp32();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 19);
        if (k == 0)
            v[30:23] = 8'h00;
        else if (k == 1)
            v[30:23] = 8'hFF;
        else if (k == 2) begin
            v[30:23] = 8'hFF;
            v[22:0] = '0;
        end else if (k < 11)
            v[30:23] = 8'($urandom_range(1, 254));
        else
            v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue32_ready_timeout", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait32(output int lat, output bit rdy_bad);
        lat = -1;
        rdy_bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) rdy_bad = 1'b1;
            if (out_valid) begin
                lat = c + 1;
                break;
            end
        end
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!h_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!h_in_ready) chk("issue16_ready_timeout", {31'b0, h_in_ready}, 32'h1);
        h_in_valid = 1'b1;
        h_in_a = a;
        h_in_b = b;
        h_in_tag = tag;
        @(posedge clk);
        #1 h_in_valid = 1'b0;
    endtask

    task automatic wait16(output int lat);
        lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (h_out_valid) begin
                lat = c + 1;
                break;
            end
        end
    endtask

    vec_t tbl[7];

    initial begin
        int   lat;
        bit   rdy_bad, seen;
        res_t r;
        logic [31:0] a, b;
        logic [15:0] ha, hb;

        tbl[0] = '{32'h40C00000, 32'h40400000, 8'h11, 32'h40000000, 5'b00000, 28};
        tbl[1] = '{32'h3F800000, 32'h40400000, 8'h12, 32'h3EAAAAAB, 5'b00001, 28};
        tbl[2] = '{32'h3F800000, 32'h00000000, 8'h13, 32'h7F800000, 5'b01000, 2};
        tbl[3] = '{32'h00000000, 32'h00000000, 8'h14, 32'h7FC00000, 5'b10000, 2};
        tbl[4] = '{32'hBF800000, 32'h7F800000, 8'h15, 32'h80000000, 5'b00000, 2};
        tbl[5] = '{32'h7F7FFFFF, 32'h3F000000, 8'h16, 32'h7F800000, 5'b00101, 28};
        tbl[6] = '{32'h00800000, 32'h40000000, 8'h17, 32'h00000000, 5'b00011, 28};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_tag", {24'b0, out_tag}, 32'h0);
        chk("rst_out_flags", {27'b0, out_flags}, 32'h0);
        chk("rst_h_in_ready", {31'b0, h_in_ready}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Directed FP32 table
        foreach (tbl[i]) begin
            issue32(tbl[i].a, tbl[i].b, tbl[i].tag);
            wait32(lat, rdy_bad);
            chk($sformatf("dir%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("dir%0d_busy_ready", i), {31'b0, rdy_bad}, 32'h0);
            chk($sformatf("dir%0d_data", i), out_data, tbl[i].data);
            chk($sformatf("dir%0d_flags", i), {27'b0, out_flags}, {27'b0, tbl[i].flags});
            chk($sformatf("dir%0d_tag", i), {24'b0, out_tag}, {24'b0, tbl[i].tag});
            @(negedge clk);
            chk($sformatf("dir%0d_ready_after", i), {30'b0, in_ready, out_valid}, 32'h2);
        end

        // Back-pressure in OUT
        out_ready = 1'b0;
        issue32(32'h40C00000, 32'h40400000, 8'h22);
        wait32(lat, rdy_bad);
        chk("bp_lat", lat, 28);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_data", out_data, 32'h40000000);
            chk("bp_hold_tag", {24'b0, out_tag}, 32'h22);
            chk("bp_hold_flags", {27'b0, out_flags}, 32'h0);
            chk("bp_hold_hs", {30'b0, in_ready, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_hs", {30'b0, in_ready, out_valid}, 32'h2);

        // Reset in the middle of DIV
        issue32(32'h3F800000, 32'h40400000, 8'h33);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("midrst_out_tag", {24'b0, out_tag}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", {31'b0, seen}, 32'h0);
        chk("midrst_ready_back", {31'b0, in_ready}, 32'h1);

        // Randomized FP32 against the reference model
        for (int i = 0; i < 200; i++) begin
            a = rand_fp32();
            b = rand_fp32();
            r = ref_div(a, b, 8, 23);
            issue32(a, b, 8'(i));
            wait32(lat, rdy_bad);
            chk($sformatf("rnd%0d_data a=%h b=%h", i, a, b), out_data, r.data);
            chk($sformatf("rnd%0d_flags a=%h b=%h", i, a, b), {27'b0, out_flags}, {27'b0, r.flags});
            chk($sformatf("rnd%0d_tag", i), {24'b0, out_tag}, {24'b0, 8'(i)});
            chk($sformatf("rnd%0d_lat", i), lat, r.lat);
            @(negedge clk);
            chk($sformatf("rnd%0d_ready_after", i), {31'b0, in_ready}, 32'h1);
        end

        // FP16 instance
        issue16(16'h4600, 16'h4200, 8'h51);
        wait16(lat);
        chk("h_lat", lat, 15);
        chk("h_data", {16'b0, h_out_data}, 32'h4000);
        chk("h_flags", {27'b0, h_out_flags}, 32'h0);
        chk("h_tag", {24'b0, h_out_tag}, 32'h51);
        for (int i = 0; i < 6; i++) begin
            ha = 16'($urandom);
            hb = 16'($urandom);
            ha[14:10] = 5'($urandom_range(8, 22));
            hb[14:10] = 5'($urandom_range(8, 22));
            r = ref_div({16'b0, ha}, {16'b0, hb}, 5, 10);
            issue16(ha, hb, 8'h60 + 8'(i));
            wait16(lat);
            chk($sformatf("h_b2b%0d_data a=%h b=%h", i, ha, hb), {16'b0, h_out_data}, r.data);
            chk($sformatf("h_b2b%0d_flags", i), {27'b0, h_out_flags}, {27'b0, r.flags});
            chk($sformatf("h_b2b%0d_tag", i), {24'b0, h_out_tag}, {24'b0, 8'h60 + 8'(i)});
            chk($sformatf("h_b2b%0d_lat", i), lat, 15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Parametrised iterative IEEE-754 floating-point divider for the force/LJ arithmetic datapath.
- Successor to the fixed-FP32 combinational divider wrapper.
- Computes a/b with round-to-nearest-even and exception flags, using a radix-2 restoring mantissa divider.
- Uses valid/ready handshakes on both sides and carries a tag through, so callers can back-pressure and match results to requests.

Parameters:
- EXP_W, 8: exponent width. 8 selects FP32; 5 selects FP16.
- MANT_W, 23: stored mantissa width, without the hidden bit.
- TAG_W, 8: width of the opaque tag carried from input to output.
- Derived, not overridable: W = 1+EXP_W+MANT_W; BIAS = 2^(EXP_W-1)-1; QB = MANT_W+3, the number of quotient bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair is valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  W  numerator.
- in_b  in  W  denominator.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  W  quotient.
- out_tag  out  TAG_W  tag of the request that produced out_data.
- out_flags  out  5  {invalid, divz, overflow, underflow, inexact}.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is asynchronous and active-low (rst_n).
  - While reset is asserted: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_tag=0, out_flags=0.
  - in_ready rises in the first cycle after rst_n deasserts.
- State machine: IDLE, DIV, ROUND, OUT.
  - IDLE: in_ready=1. in_valid&&in_ready latches the operands and tag (the accept edge).
    - Special-case operand pair: go to ROUND.
    - Otherwise: go to DIV.
  - DIV: one quotient bit per cycle for exactly QB cycles; iteration counter runs 0..QB-1, then go to ROUND.
  - ROUND: normalise, round, compute exponent and flags, register all outputs, go to OUT.
  - OUT: out_valid=1. out_data, out_tag and out_flags are held stable until out_valid&&out_ready, then go to IDLE.
- Handshake and timing:
  - in_ready is high only in IDLE and depends on state only, never on out_ready.
  - Latency: with the accept edge as cycle 0, out_valid rises in cycle QB+2 for normal operands (28 for FP32, 15 for FP16) and in cycle 2 for special cases.
  - Maximum throughput is one result per latency+1 cycles.
  - When out_ready is already high in the first OUT cycle, the transfer completes in that cycle and in_ready returns the next cycle.
- Operand classes:
  - Denormals-are-zero: any input with exponent 0 is treated as signed zero.
  - Result sign is sign(a) XOR sign(b) for all non-NaN results.
- Special cases (checked in priority order):
  - NaN on either input, 0/0, or inf/inf: canonical qNaN (exp all-ones, mantissa MSB=1, rest 0, sign 0). invalid=1.
  - finite nonzero / 0: signed inf. divz=1.
  - inf / finite: signed inf. No flags.
  - 0 / nonzero, or finite / inf: signed zero. No flags.
- Normal path:
  - Significands ma={1,mant_a}, mb={1,mant_b}; QB quotient bits of ma/mb.
  - sticky = OR(remainder != 0).
  - If the quotient is below 1, shift left by 1 and use exponent e = ea - eb + BIAS - 1; otherwise e = ea - eb + BIAS.
  - Compute e in signed EXP_W+2 bits.
  - Round to nearest even on the guard, round and sticky bits. A mantissa carry out increments e.
  - inexact = guard|round|sticky.
- Range handling, applied after rounding:
  - e >= 2^EXP_W-1: signed inf; overflow=1, inexact=1.
  - e <= 0: flush to signed zero; underflow=1, inexact=1.
- Reset mid-operation: the in-flight result and tag are discarded; no out_valid pulse follows reset.
- in_valid asserted while busy is ignored; upstream must hold it until in_ready.

Decomposition:
- Package fp_div_pkg holds:
  - the state enum;
  - the flag bit indices FLG_INV, FLG_DIVZ, FLG_OVF, FLG_UNF, FLG_INX;
  - the class decode function (zero/inf/nan/normal), parametrised by EXP_W and MANT_W.
- One natural sub-module, fp_div_round: the combinational normalise/round/exponent/flag logic used in ROUND.
- The FSM, restoring divider and registers stay in fp_div_iter.

Test Plan:
- FP32 0x40C00000/0x40400000, tag 0x11:
  - out_data=0x40000000, out_flags=0, out_tag=0x11.
  - out_valid rises 28 cycles after accept; in_ready is low for the whole interval.
- FP32 0x3F800000/0x40400000: out_data=0x3EAAAAAB, out_flags=00001 (inexact).
- FP32 specials, each with out_valid at cycle 2:
  - 0x3F800000/0x00000000 -> 0x7F800000, flags 01000.
  - 0x00000000/0x00000000 -> 0x7FC00000, flags 10000.
  - 0xBF800000/0x7F800000 -> 0x80000000, flags 0.
- FP32 range limits:
  - 0x7F7FFFFF/0x3F000000 -> 0x7F800000, flags 00101.
  - 0x00800000/0x40000000 -> 0x00000000, flags 00011.
- Back-pressure then reset:
  - Hold out_ready=0 for 10 cycles in OUT: out_data, out_tag and out_flags stay constant and in_ready stays 0. The transfer completes when out_ready=1, and in_ready is 1 the next cycle.
  - Then assert rst_n=0 during cycle 10 of DIV: out_valid stays 0 and no result appears after release.
- FP16 instance (EXP_W=5, MANT_W=10): 0x4600/0x4200 -> 0x4000, out_valid at cycle 15. Back-to-back requests return tags in order.
